// File: rtl/seg_sched_pkg.sv
// rtl/seg_sched_pkg.sv - shared state type, digit geometry and default timing for the display scheduler
package seg_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        URGENT
    } seg_sched_state_t;

    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 4;
    localparam int DATA_W  = DIGITS * DIGIT_W;

    localparam int DEF_HOLD_CYCLES  = 100_000_000;
    localparam int DEF_BLINK_CYCLES = 25_000_000;

    // Circular successor of a source index.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/seg_rr_pick.sv
// rtl/seg_rr_pick.sv - combinational circular search: first set mask bit at or after a start index
module seg_rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_SRC-1:0] i_mask,
    input  logic [SEL_W-1:0]   i_start,
    output logic [SEL_W-1:0]   o_idx,
    output logic               o_found
);

    always_comb begin
        int best;
        int off;
        o_idx   = '0;
        o_found = 1'b0;
        best    = NUM_SRC;
        off     = 0;
        // Distance from start, measured circularly; the smallest distance wins.
        for (int j = 0; j < NUM_SRC; j++) begin
            off = j - int'(i_start);
            if (off < 0) begin
                off = off + NUM_SRC;
            end
            if (i_mask[j] && (off < best)) begin
                best    = off;
                o_idx   = SEL_W'(j);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_disp_sched.sv
// rtl/seg_disp_sched.sv - round-robin / urgent-preempt scheduler sharing one seven-segment driver
// Optional build macro SEG_BLINK_EN: blink all dots while an urgent source is shown.
module seg_disp_sched
    import seg_sched_pkg::*;
#(
    parameter int  NUM_SRC      = 4,
    parameter int  HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int  BLINK_CYCLES = DEF_BLINK_CYCLES,
    localparam int SEL_W        = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        i_src_valid,
    input  logic [NUM_SRC-1:0]        i_src_urgent,
    input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
    input  logic [NUM_SRC*DIGITS-1:0] i_src_dots,
    input  logic                      i_freeze,
    output logic [DATA_W-1:0]         o_data,
    output logic [DIGITS-1:0]         o_dots,
    output logic [SEL_W-1:0]          o_sel,
    output logic                      o_active
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    if (NUM_SRC < 2 || NUM_SRC > 8 || HOLD_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_cfg
        $error("seg_disp_sched: unsupported parameter values");
    end

    seg_sched_state_t  state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  resume_q, resume_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DIGITS-1:0] dots_q, dots_d;
    logic              active_q, active_d;

    logic [NUM_SRC-1:0] urg_mask;
    logic               urg_any;
    logic [SEL_W-1:0]   urg_idx;
    logic [SEL_W-1:0]   next_sel;
    logic [SEL_W-1:0]   rot_idx;
    logic               rot_found;
    logic [SEL_W-1:0]   res_idx;
    logic               res_found;
    logic [DATA_W-1:0]  data_sel;
    logic [DIGITS-1:0]  dots_sel;

    assign urg_mask = i_src_urgent & i_src_valid;
    assign urg_any  = |urg_mask;
    assign next_sel = SEL_W'(wrap_inc(int'(sel_q), NUM_SRC));

    always_comb begin
        urg_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (urg_mask[k]) begin
                urg_idx = SEL_W'(k);
            end
        end
    end

    // Rotation and drop-out both search onward from the successor of the shown source.
    seg_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_pick_rot (
        .i_mask  (i_src_valid),
        .i_start (next_sel),
        .o_idx   (rot_idx),
        .o_found (rot_found)
    );

    seg_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_pick_res (
        .i_mask  (i_src_valid),
        .i_start (resume_q),
        .o_idx   (res_idx),
        .o_found (res_found)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        resume_d = resume_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (urg_any) begin
                    state_d = URGENT;
                    sel_d   = urg_idx;
                end else if (res_found) begin
                    state_d = SHOW;
                    sel_d   = res_idx;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (urg_any) begin
                    state_d  = URGENT;
                    sel_d    = urg_idx;
                    resume_d = sel_q;
                end else if (!i_src_valid[sel_q]) begin
                    cnt_d = '0;
                    if (rot_found) begin
                        sel_d = rot_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!i_freeze) begin
                    if (cnt_q == HOLD_LAST) begin
                        sel_d = rot_idx;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            URGENT: begin
                if (urg_any) begin
                    sel_d = urg_idx;
                end else begin
                    cnt_d = '0;
                    if (res_found) begin
                        state_d = SHOW;
                        sel_d   = res_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Data follows the next selection so o_sel/o_data/o_dots switch together.
    always_comb begin
        data_sel = '0;
        dots_sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel_d == SEL_W'(k)) begin
                data_sel = i_src_data[k*DATA_W +: DATA_W];
                dots_sel = i_src_dots[k*DIGITS +: DIGITS];
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BCNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BCNT_W-1:0] BLINK_LAST = BCNT_W'(BLINK_CYCLES - 1);

    logic              blink_q, blink_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
`endif

    always_comb begin
        active_d = (state_d != IDLE);
        data_d   = data_q;
        dots_d   = dots_q;
        if (active_d) begin
            data_d = data_sel;
            dots_d = dots_sel;
        end
`ifdef SEG_BLINK_EN
        blink_d = 1'b0;
        bcnt_d  = '0;
        if (state_d == URGENT) begin
            if (state_q != URGENT) begin
                blink_d = 1'b1;
            end else if (bcnt_q == BLINK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blink_d = blink_q;
                bcnt_d  = bcnt_q + 1'b1;
            end
            dots_d = {DIGITS{blink_d}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            resume_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            dots_q   <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            resume_q <= resume_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            dots_q   <= dots_d;
            active_q <= active_d;
        end
    end

`ifdef SEG_BLINK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            blink_q <= blink_d;
            bcnt_q  <= bcnt_d;
        end
    end
`endif

    assign o_data   = data_q;
    assign o_dots   = dots_q;
    assign o_sel    = sel_q;
    assign o_active = active_q;

endmodule
